// File: rtl/echo_request_input_if.sv
// Request-pipe and decoded-call method handshakes of the echo portal request path.
// The slave modport is the deserializer; the master modport is the host/core side.
interface echo_request_input_if;
    logic [31:0] requests_0_enq_v;
    logic        EN_requests_0_enq;
    logic        RDY_requests_0_enq;
    logic [31:0] say_v;
    logic        RDY_say;
    logic        EN_say;
    logic [31:0] say2_a;
    logic [31:0] say2_b;
    logic        RDY_say2;
    logic        EN_say2;

    modport slave (
        input  requests_0_enq_v, EN_requests_0_enq, EN_say, EN_say2,
        output RDY_requests_0_enq, say_v, RDY_say, say2_a, say2_b, RDY_say2
    );

    modport master (
        output requests_0_enq_v, EN_requests_0_enq, EN_say, EN_say2,
        input  RDY_requests_0_enq, say_v, RDY_say, say2_a, say2_b, RDY_say2
    );
endinterface

// File: rtl/echo_request_input.sv
// Echo portal request deserializer: frames -> say/say2 call FIFO -> RDY/EN methods.
// Define ECHO_REQ_ERRCNT_EN to implement the saturating malformed-frame counter.
module echo_request_input #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    echo_request_input_if.slave       req,
    input  logic [15:0]               messageSize_size_methodNumber,
    output logic [15:0]               messageSize_size,
    output logic                      RDY_messageSize_size,
    output logic [7:0]                err_count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StPayload, StDiscard} state_e;

    state_e      state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic        method_q, method_d;
    logic [31:0] a_q, a_d;

    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          mem_m [DEPTH];
    logic [31:0]   mem_a [DEPTH];
    logic [31:0]   mem_b [DEPTH];

    logic        fifo_full, fifo_empty, head_m;
    logic        enq_fire, push, pop, hdr_legal;
    logic [31:0] word, push_a;
    logic [15:0] hdr_method, hdr_count;

    assign word       = req.requests_0_enq_v;
    assign hdr_method = word[31:16];
    assign hdr_count  = word[15:0];
    assign hdr_legal  = (hdr_method == 16'd0 && hdr_count == 16'd1) ||
                        (hdr_method == 16'd1 && hdr_count == 16'd2);

    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    // Only the final payload word pushes, so only it can be held off by a full FIFO.
    assign req.RDY_requests_0_enq = !(state_q == StPayload && remaining_q == 16'd1 && fifo_full);
    assign enq_fire = req.EN_requests_0_enq && req.RDY_requests_0_enq;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        method_d    = method_q;
        a_d         = a_q;
        push        = 1'b0;
        if (enq_fire) begin
            case (state_q)
                StIdle: begin
                    remaining_d = hdr_count;
                    if (hdr_legal) begin
                        state_d  = StPayload;
                        method_d = word[16];
                    end else if (hdr_count != 16'd0) begin
                        state_d = StDiscard;
                    end
                end
                StPayload: begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        a_d = word;
                    end
                end
                StDiscard: begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            method_q    <= 1'b0;
            a_q         <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            method_q    <= method_d;
            a_q         <= a_d;
        end
    end

    // A say call has one payload word, which is its argument and also its final word.
    assign push_a = method_q ? a_q : word;
    assign head_m = mem_m[rd_idx];
    assign pop    = (req.EN_say && req.RDY_say) || (req.EN_say2 && req.RDY_say2);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_m[i] <= 1'b0;
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_m[wr_idx] <= method_q;
                mem_a[wr_idx] <= push_a;
                mem_b[wr_idx] <= word;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign req.RDY_say  = !fifo_empty && !head_m;
    assign req.RDY_say2 = !fifo_empty && head_m;
    assign req.say_v    = mem_a[rd_idx];
    assign req.say2_a   = mem_a[rd_idx];
    assign req.say2_b   = mem_b[rd_idx];

    always_comb begin
        case (messageSize_size_methodNumber)
            16'd0:   messageSize_size = 16'd32;
            16'd1:   messageSize_size = 16'd64;
            default: messageSize_size = 16'd0;
        endcase
    end
    assign RDY_messageSize_size = 1'b1;

`ifdef ECHO_REQ_ERRCNT_EN
    logic [7:0] err_q;
    logic       hdr_bad;

    assign hdr_bad = enq_fire && state_q == StIdle && !hdr_legal;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                        err_q <= '0;
        else if (hdr_bad && err_q != 8'hff) err_q <= err_q + 8'd1;
    end
    assign err_count = err_q;
`else
    assign err_count = 8'd0;
`endif
endmodule

// File: tb/tb_echo_request_input.sv
// Self-checking bench for echo_request_input: directed scenarios plus random frames
// checked every cycle against a frame-level model (call queue + error tally).
module tb_echo_request_input;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] w;
        logic [1:0]  tag;  // 0 plain word, 1 final word of a legal call, 2 malformed header
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
    } word_t;

    typedef struct packed {
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
    } call_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] ms_num;
    logic [15:0] ms_size;
    logic        ms_rdy;
    logic [7:0]  err_count;

    echo_request_input_if req_if ();

    echo_request_input #(.DEPTH(DEPTH)) dut (
        .CLK                           (CLK),
        .RST_N                         (RST_N),
        .req                           (req_if.slave),
        .messageSize_size_methodNumber (ms_num),
        .messageSize_size              (ms_size),
        .RDY_messageSize_size          (ms_rdy),
        .err_count                     (err_count)
    );

    always #5 CLK = ~CLK;

    word_t stream[$];
    call_t model[$];
    int    err_exp;
    int    n_checks;
    int    n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_say(input logic [31:0] v);
        stream.push_back('{w: 32'h0000_0001, tag: 2'd0, m: 1'b0, a: '0, b: '0});
        stream.push_back('{w: v, tag: 2'd1, m: 1'b0, a: v, b: v});
    endtask

    task automatic add_say2(input logic [31:0] a, input logic [31:0] b);
        stream.push_back('{w: 32'h0001_0002, tag: 2'd0, m: 1'b0, a: '0, b: '0});
        stream.push_back('{w: a, tag: 2'd0, m: 1'b0, a: '0, b: '0});
        stream.push_back('{w: b, tag: 2'd1, m: 1'b1, a: a, b: b});
    endtask

    task automatic add_bad(input logic [15:0] meth, input logic [15:0] cnt);
        stream.push_back('{w: {meth, cnt}, tag: 2'd2, m: 1'b0, a: '0, b: '0});
        for (int i = 0; i < int'(cnt); i++)
            stream.push_back('{w: $urandom, tag: 2'd0, m: 1'b0, a: '0, b: '0});
    endtask

    // One cycle: check outputs against the model, drive, clock, update the model.
    task automatic step(input bit send, input bit en_s, input bit en_s2);
        bit    exp_rdy, acc, pop;
        word_t cur;
        exp_rdy = !(stream.size() > 0 && stream[0].tag == 2'd1 && model.size() == DEPTH);
        check_eq("rdy_enq", req_if.RDY_requests_0_enq, exp_rdy);
        if (model.size() == 0) begin
            check_eq("rdy_say_empty", req_if.RDY_say, 0);
            check_eq("rdy_say2_empty", req_if.RDY_say2, 0);
        end else begin
            check_eq("rdy_say", req_if.RDY_say, !model[0].m);
            check_eq("rdy_say2", req_if.RDY_say2, model[0].m);
            if (!model[0].m) begin
                check_eq("say_v", req_if.say_v, model[0].a);
            end else begin
                check_eq("say2_a", req_if.say2_a, model[0].a);
                check_eq("say2_b", req_if.say2_b, model[0].b);
            end
        end
`ifdef ECHO_REQ_ERRCNT_EN
        check_eq("err_count", err_count, err_exp);
`else
        check_eq("err_count", err_count, 0);
`endif
        acc = send && exp_rdy && stream.size() > 0;
        pop = model.size() > 0 && (model[0].m ? en_s2 : en_s);
        req_if.EN_say            = en_s;
        req_if.EN_say2           = en_s2;
        req_if.EN_requests_0_enq = acc;
        req_if.requests_0_enq_v  = acc ? stream[0].w : $urandom;
        @(posedge CLK);
        if (pop) void'(model.pop_front());
        if (acc) begin
            cur = stream.pop_front();
            if (cur.tag == 2'd1) model.push_back('{m: cur.m, a: cur.a, b: cur.b});
            if (cur.tag == 2'd2 && err_exp < 255) err_exp++;
        end
        #1;
        req_if.EN_say            = 1'b0;
        req_if.EN_say2           = 1'b0;
        req_if.EN_requests_0_enq = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rdy_enq"}, req_if.RDY_requests_0_enq, 1);
        check_eq({tag, "_rdy_say"}, req_if.RDY_say, 0);
        check_eq({tag, "_rdy_say2"}, req_if.RDY_say2, 0);
        check_eq({tag, "_say_v"}, req_if.say_v, 0);
        check_eq({tag, "_say2_a"}, req_if.say2_a, 0);
        check_eq({tag, "_say2_b"}, req_if.say2_b, 0);
        check_eq({tag, "_err"}, err_count, 0);
    endtask

    initial begin
        int          guard;
        logic [15:0] meth;
        logic [15:0] cnt;
        n_checks = 0;
        n_fail   = 0;
        err_exp  = 0;
        ms_num   = 16'd0;
        req_if.requests_0_enq_v  = '0;
        req_if.EN_requests_0_enq = 1'b0;
        req_if.EN_say            = 1'b0;
        req_if.EN_say2           = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        check_idle_outputs("reset");
        check_eq("ms_rdy", ms_rdy, 1);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // say, then say2
        add_say(32'hDEAD_BEEF);
        repeat (2) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        add_say2(32'h1111_1111, 32'h2222_2222);
        repeat (3) step(1, 0, 0);
        step(0, 1, 0);  // wrong method enable must be ignored
        step(0, 0, 1);
        step(0, 0, 0);

        // Fill the FIFO: fifth final word stalls until one pop
        for (int v = 1; v <= 5; v++) add_say(v);
        repeat (12) step(1, 0, 0);
        check_eq("stall_left", stream.size(), 1);
        step(1, 1, 0);
        step(1, 0, 0);
        check_eq("stall_released", stream.size(), 0);
        repeat (6) step(0, 1, 0);

        // Malformed frames
        add_bad(16'h0007, 16'd3);
        add_say(32'd9);
        repeat (7) step(1, 0, 0);
        step(0, 1, 0);
        add_bad(16'h0000, 16'd0);
        step(1, 0, 0);
        add_say(32'd10);
        repeat (2) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
`ifdef ECHO_REQ_ERRCNT_EN
        check_eq("err_after_bad", err_count, 2);
`endif

        // Reset mid-say2 with a queued call
        add_say(32'd5);
        add_say2(32'hAAAA_0001, 32'hBBBB_0002);
        repeat (4) step(1, 0, 0);
        RST_N = 1'b0;
        #2;
        check_idle_outputs("midreset");
        stream.delete();
        model.delete();
        err_exp = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        add_say(32'h0000_1234);
        repeat (2) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);

        // messageSize
        ms_num = 16'd0; #1 check_eq("ms_0", ms_size, 32);
        ms_num = 16'd1; #1 check_eq("ms_1", ms_size, 64);
        ms_num = 16'd5; #1 check_eq("ms_5", ms_size, 0);
        for (int i = 0; i < 8; i++) begin
            ms_num = 16'($urandom_range(2, 65535));
            #1 check_eq("ms_rand", ms_size, 0);
        end
        @(posedge CLK);
        #1;

        // Random frames with random consumer
        for (int f = 0; f < 60; f++) begin
            case ($urandom_range(0, 2))
                0: add_say($urandom);
                1: add_say2($urandom, $urandom);
                default: begin
                    meth = 16'($urandom_range(0, 3));
                    cnt  = 16'($urandom_range(0, 3));
                    if ((meth == 16'd0 && cnt == 16'd1) || (meth == 16'd1 && cnt == 16'd2))
                        cnt = 16'd3;
                    add_bad(meth, cnt);
                end
            endcase
        end
        guard = 0;
        while ((stream.size() > 0 || model.size() > 0) && guard < 3000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
            guard++;
        end
        check_eq("drain_timeout", guard < 3000, 1);
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
